// File: rtl/ct_spsram_taint_pkg.sv
// Shared types and helpers for the taint-tracking single-port SRAM.
package ct_spsram_taint_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CLR  = 1'b1
    } clr_state_e;

    localparam int unsigned MAX_DATA_WIDTH = 1024;

    // All-ones mask of the low `width` bits; callers slice to their word width.
    function automatic logic [MAX_DATA_WIDTH-1:0] ones_mask(input int unsigned width);
        logic [MAX_DATA_WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ct_spsram_taint_clr.sv
// Shadow clear sequencer: after reset walks every entry once, zeroing it.
module ct_spsram_taint_clr
    import ct_spsram_taint_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLR: begin
                // Last entry is written on the same edge that drops BUSY; ptr never wraps.
                if (ptr_q == PTR_MAX) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == ST_CLR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/ct_spsram_taint.sv
// Single-port SRAM with per-bit taint shadow and conservative control/address taint.
module ct_spsram_taint
    import ct_spsram_taint_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 52,
    parameter int WE_WIDTH   = 52,
    parameter bit TAINT_EN   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [ADDR_WIDTH-1:0] A_t0,
    input  logic                  CEN,
    input  logic                  CEN_t0,
    input  logic                  GWEN,
    input  logic                  GWEN_t0,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [WE_WIDTH-1:0]   WEN_t0,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] D_t0,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] Q_t0,
    output logic                  BUSY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [MAX_DATA_WIDTH-1:0] ONES_FULL = ones_mask(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0]     ONES      = ONES_FULL[DATA_WIDTH-1:0];

    logic                  rd, wr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] q_q, q_d;

    assign rd = ~CEN & GWEN;
    assign wr = ~CEN & ~GWEN;

    // Behavioural data array; never reset, so unwritten entries read X.
    always_ff @(posedge CLK) begin
        if (!RST && wr) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
    end

    always_comb begin
        q_d = q_q;
        if (rd) q_d = mem[A];
    end

    always_ff @(posedge CLK) begin
        if (RST) q_q <= '0;
        else     q_q <= q_d;
    end

    assign Q = q_q;

    if (TAINT_EN) begin : g_taint
        logic                  busy, clr_we;
        logic [ADDR_WIDTH-1:0] clr_addr;
        logic [DATA_WIDTH-1:0] shadow [0:DEPTH-1];
        logic                  ctl_t, a_t;
        logic [DATA_WIDTH-1:0] sh_upd, sh_new, sh_rd;
        logic                  atw_q, atw_d;
        logic [DATA_WIDTH-1:0] q_t0_q, q_t0_d;

        ct_spsram_taint_clr #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
            .clk      (CLK),
            .rst      (RST),
            .busy     (busy),
            .clr_we   (clr_we),
            .clr_addr (clr_addr)
        );

        always_comb begin
            ctl_t  = CEN_t0 | GWEN_t0;
            a_t    = |A_t0;
            // A tainted enable means the bit may or may not have been written.
            sh_upd = ~WEN | WEN_t0;
            sh_new = D_t0 | WEN_t0 | {DATA_WIDTH{ctl_t}};
            sh_rd  = shadow[A];
            atw_d  = atw_q | ((wr | ctl_t) & a_t);
            q_t0_d = q_t0_q;
            if (rd)         q_t0_d = busy ? ONES : (sh_rd | {DATA_WIDTH{ctl_t | a_t | atw_q}});
            else if (ctl_t) q_t0_d = ONES;
        end

        // clr_we is high for the whole clear, which also locks out user shadow updates.
        always_ff @(posedge CLK) begin
            if (clr_we) begin
                shadow[clr_addr] <= '0;
            end else if (!RST) begin
                if (wr)         shadow[A] <= (shadow[A] & ~sh_upd) | (sh_new & sh_upd);
                else if (ctl_t) shadow[A] <= ONES;
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                atw_q  <= 1'b0;
                q_t0_q <= '0;
            end else begin
                atw_q  <= atw_d;
                q_t0_q <= q_t0_d;
            end
        end

        assign BUSY = busy;
        assign Q_t0 = q_t0_q;
    end else begin : g_no_taint
        assign BUSY = 1'b0;
        assign Q_t0 = '0;
    end

endmodule

// File: tb/tb_ct_spsram_taint.sv
// Table-driven scoreboard bench for ct_spsram_taint (default 256 x 52 geometry).
module tb_ct_spsram_taint;

    localparam logic [51:0] ALL = '1;
    localparam logic [51:0] Z52 = '0;

    logic        clk, rst;
    logic [7:0]  a, a_t0;
    logic        cen, cen_t0, gwen, gwen_t0;
    logic [51:0] wen, wen_t0, d, d_t0;
    logic [51:0] q, q_t0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       nm;
        logic        cen, gwen, cen_t, gwen_t;
        logic [7:0]  a, a_t;
        logic [51:0] wen, wen_t, d, d_t;
        logic        cq;
        logic [51:0] eq, eqt;
    } vec_t;

    typedef struct {
        string       nm;
        logic        cq;
        logic [51:0] q, qt;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    ct_spsram_taint dut (
        .CLK(clk), .RST(rst),
        .A(a), .A_t0(a_t0),
        .CEN(cen), .CEN_t0(cen_t0),
        .GWEN(gwen), .GWEN_t0(gwen_t0),
        .WEN(wen), .WEN_t0(wen_t0),
        .D(d), .D_t0(d_t0),
        .Q(q), .Q_t0(q_t0),
        .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic c, input logic g, input logic ct,
                                input logic gt, input logic [7:0] ad, input logic [7:0] at,
                                input logic [51:0] w, input logic [51:0] wt, input logic [51:0] dd,
                                input logic [51:0] dt, input logic cq, input logic [51:0] eq,
                                input logic [51:0] eqt);
        vec_t v;
        v.nm = nm; v.cen = c; v.gwen = g; v.cen_t = ct; v.gwen_t = gt;
        v.a = ad; v.a_t = at; v.wen = w; v.wen_t = wt; v.d = dd; v.d_t = dt;
        v.cq = cq; v.eq = eq; v.eqt = eqt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [51:0] act, input logic [51:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cen = v.cen; gwen = v.gwen; cen_t0 = v.cen_t; gwen_t0 = v.gwen_t;
        a = v.a; a_t0 = v.a_t; wen = v.wen; wen_t0 = v.wen_t; d = v.d; d_t0 = v.d_t;
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        drive(v);
        e.nm = v.nm; e.cq = v.cq; e.q = v.eq; e.qt = v.eqt;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        if (e.cq) chk({e.nm, ".q"}, q, e.q);
        chk({e.nm, ".qt"}, q_t0, e.qt);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   nb;
        vec_t idle;
        idle = mk("idle", 1, 1, 0, 0, 8'h00, 8'h00, ALL, Z52, Z52, Z52, 0, Z52, Z52);
        rst = 1'b1;
        drive(idle);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.q", q, Z52);
        chk("rst.qt", q_t0, Z52);
        chk("rst.busy", {51'b0, busy}, 52'd1);
        rst = 1'b0;
        count_busy(nb);
        chk("clear_len", 52'(nb), 52'd256);
        chk("post_clr.q", q, Z52);
        chk("post_clr.qt", q_t0, Z52);

        //           name      cen gw ct gt  A      A_t0   WEN        WEN_t0  D            D_t0         cq Q            Q_t0
        vt.push_back(mk("rd00",   0, 1, 0, 0, 8'h00, 8'h00, ALL,       Z52,    Z52,         Z52,         0, Z52,         Z52));
        vt.push_back(mk("rdff",   0, 1, 0, 0, 8'hff, 8'h00, ALL,       Z52,    Z52,         Z52,         0, Z52,         Z52));
        vt.push_back(mk("wr10",   0, 0, 0, 0, 8'h10, 8'h00, Z52,       Z52,    52'hA5,      52'h01,      0, Z52,         Z52));
        vt.push_back(mk("rd10a",  0, 1, 0, 0, 8'h10, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'hA5,      52'h01));
        vt.push_back(mk("rd33",   0, 1, 0, 0, 8'h33, 8'h00, ALL,       Z52,    Z52,         Z52,         0, Z52,         Z52));
        vt.push_back(mk("wrpart", 0, 0, 0, 0, 8'h10, 8'h00, ~52'hF0,   Z52,    52'h30,      Z52,         0, Z52,         Z52));
        vt.push_back(mk("rd10b",  0, 1, 0, 0, 8'h10, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'h35,      52'h01));
        vt.push_back(mk("wrwent", 0, 0, 0, 0, 8'h10, 8'h00, ~52'hF0,   52'h01, 52'hC0,      Z52,         1, 52'h35,      52'h01));
        vt.push_back(mk("rd10c",  0, 1, 0, 0, 8'h10, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'hC5,      52'h01));
        vt.push_back(mk("wr40",   0, 0, 0, 0, 8'h40, 8'h00, Z52,       Z52,    52'hFFFF,    Z52,         1, 52'hC5,      52'h01));
        vt.push_back(mk("rd40a",  0, 1, 0, 0, 8'h40, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'hFFFF,    Z52));
        vt.push_back(mk("wr41",   0, 0, 0, 0, 8'h41, 8'h00, Z52,       Z52,    52'h123,     52'hF0F0,    1, 52'hFFFF,    Z52));
        vt.push_back(mk("rd41a",  0, 1, 0, 0, 8'h41, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'h123,     52'hF0F0));
        vt.push_back(mk("rdat",   0, 1, 0, 0, 8'h40, 8'h01, ALL,       Z52,    Z52,         Z52,         1, 52'hFFFF,    ALL));
        vt.push_back(mk("rd40b",  0, 1, 0, 0, 8'h40, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'hFFFF,    Z52));
        vt.push_back(mk("idlect", 1, 1, 1, 0, 8'h50, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'hFFFF,    ALL));
        vt.push_back(mk("rd40c",  0, 1, 0, 0, 8'h40, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'hFFFF,    Z52));
        vt.push_back(mk("rd50",   0, 1, 0, 0, 8'h50, 8'h00, ALL,       Z52,    Z52,         Z52,         0, Z52,         ALL));
        vt.push_back(mk("wrgwt",  0, 0, 0, 1, 8'h41, 8'h00, ALL,       Z52,    52'h777,     Z52,         0, Z52,         ALL));
        vt.push_back(mk("rd41b",  0, 1, 0, 0, 8'h41, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'h123,     52'hF0F0));
        vt.push_back(mk("hold",   1, 0, 0, 0, 8'h10, 8'h00, Z52,       Z52,    52'h999,     Z52,         1, 52'h123,     52'hF0F0));
        vt.push_back(mk("rd10d",  0, 1, 0, 0, 8'h10, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'hC5,      52'h01));
        vt.push_back(mk("wratw",  0, 0, 0, 0, 8'h60, 8'h02, Z52,       Z52,    52'h7,       Z52,         1, 52'hC5,      52'h01));
        vt.push_back(mk("rd40d",  0, 1, 0, 0, 8'h40, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'hFFFF,    ALL));
        vt.push_back(mk("rd60",   0, 1, 0, 0, 8'h60, 8'h00, ALL,       Z52,    Z52,         Z52,         1, 52'h7,       ALL));
        for (int i = 0; i < vt.size(); i++) step(vt[i]);

        // Reset during the clear: restart at ptr 0, write in the RST cycle dropped, atw cleared.
        rst = 1'b1;
        step(mk("rst2", 1, 1, 0, 0, 8'h00, 8'h00, ALL, Z52, Z52, Z52, 1, Z52, Z52));
        rst = 1'b0;
        drive(idle);
        repeat (98) @(posedge clk);
        @(negedge clk);
        step(mk("rdbusy", 0, 1, 0, 0, 8'h40, 8'h00, ALL, Z52, Z52, Z52, 1, 52'hFFFF, ALL));
        chk("busy_mid", {51'b0, busy}, 52'd1);
        step(mk("wrbusy", 0, 0, 0, 0, 8'h70, 8'h00, Z52, Z52, 52'h99, 52'h1F, 1, 52'hFFFF, ALL));
        rst = 1'b1;
        step(mk("rst3wr", 0, 0, 0, 0, 8'h40, 8'h00, Z52, Z52, 52'h1, Z52, 1, Z52, Z52));
        chk("rst3.busy", {51'b0, busy}, 52'd1);
        rst = 1'b0;
        drive(idle);
        count_busy(nb);
        chk("clear_len2", 52'(nb), 52'd256);
        step(mk("rd40e", 0, 1, 0, 0, 8'h40, 8'h00, ALL, Z52, Z52, Z52, 1, 52'hFFFF, Z52));
        step(mk("rd70",  0, 1, 0, 0, 8'h70, 8'h00, ALL, Z52, Z52, Z52, 1, 52'h99, Z52));
        step(mk("rd10e", 0, 1, 0, 0, 8'h10, 8'h00, ALL, Z52, Z52, Z52, 1, 52'hC5, Z52));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
